spi_xfer_ctrl: RTL and testbench

Sequencer for the SPI master datapath, driven by the fields of the 32-bit SPI control register (send, cs_ctrl, all_1s, all_0s, n_tx_end). On send=1 it runs a burst of n_tx_end+1 byte transfers in SPI mode 0, MSB first. For each byte it fetches TX data from the transmit buffer and writes received data to the receive buffer. On completion it reports the received-byte count and pulses a clear of the send bit back to the control register.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_xfer_ctrl_if.sv | 37 +++
 rtl/spi_sclk_gen.sv | 37 +++
 rtl/spi_xfer_ctrl.sv | 123 ++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer sequencer and its control register.
// Control register field positions live here so the register block and the sequencer agree.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        STORE,
        DONE,
        WAIT_CLR
    } spi_xfer_state_t;

    localparam int SEND_BIT   = 0;
    localparam int CS_BIT     = 1;
    localparam int ONES_BIT   = 2;
    localparam int ZEROS_BIT  = 3;
    localparam int TX_END_LSB = 4;
    localparam int RX_END_LSB = 16;

    localparam logic [7:0] FILL_ONES  = 8'hFF;
    localparam logic [7:0] FILL_ZEROS = 8'h00;

    // all_1s wins over all_0s when both are set
    function automatic logic [7:0] tx_fill(input logic ones, input logic zeros,
                                           input logic [7:0] data);
        if (ones)
            return FILL_ONES;
        else if (zeros)
            return FILL_ZEROS;
        else
            return data;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of control-register, buffer and SPI pin signals around the transfer sequencer.
// master = sequencer side, slave = register/buffer/pad side.
interface spi_xfer_ctrl_if #(
    parameter int N = 5
);
    logic         send;
    logic         cs_ctrl;
    logic         all_1s;
    logic         all_0s;
    logic [N:0]   n_tx_end;
    logic [N:0]   tx_addr;
    logic [7:0]   tx_data;
    logic [N:0]   rx_addr;
    logic [7:0]   rx_data;
    logic         rx_we;
    logic [N+1:0] n_rx_cnt;
    logic         n_rx_we;
    logic         send_clr;
    logic         busy;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         cs_n;

    modport master (
        input  send, cs_ctrl, all_1s, all_0s, n_tx_end, tx_data, miso,
        output tx_addr, rx_addr, rx_data, rx_we, n_rx_cnt, n_rx_we, send_clr,
               busy, sclk, mosi, cs_n
    );

    modport slave (
        output send, cs_ctrl, all_1s, all_0s, n_tx_end, tx_data, miso,
        input  tx_addr, rx_addr, rx_data, rx_we, n_rx_cnt, n_rx_we, send_clr,
               busy, sclk, mosi, cs_n
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every DIV enabled cycles starting low; rise/fall pulses mark the
// cycle whose closing edge makes the transition. Disabled -> counter cleared, sclk held low.
module spi_sclk_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick       = en && (cnt == CW'(DIV - 1));
    assign rise_pulse = tick && !sclk;
    assign fall_pulse = tick && sclk;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 burst sequencer: n_tx_end+1 bytes MSB first, 16*DIV+2 cycles per byte.
// No backpressure: buffers are assumed always ready; send must drop before re-arming.
module spi_xfer_ctrl #(
    parameter int N   = 5,
    parameter int DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_xfer_ctrl_if.master bus
);
    import spi_pkg::*;

    spi_xfer_state_t state;
    logic [N:0]      idx;
    logic [N:0]      end_q;
    logic [6:0]      tx_sr;
    logic [7:0]      rx_sr;
    logic [2:0]      bit_cnt;
    logic [7:0]      fill;
    logic            sclk;
    logic            rise_pulse;
    logic            fall_pulse;

    spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (state == SHIFT),
        .sclk       (sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign bus.sclk = sclk;
    assign fill     = tx_fill(bus.all_1s, bus.all_0s, bus.tx_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            end_q        <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            bus.mosi     <= 1'b0;
            bus.cs_n     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.rx_we    <= 1'b0;
            bus.n_rx_we  <= 1'b0;
            bus.send_clr <= 1'b0;
            bus.tx_addr  <= '0;
            bus.rx_addr  <= '0;
            bus.rx_data  <= '0;
            bus.n_rx_cnt <= '0;
        end else begin
            bus.rx_we    <= 1'b0;
            bus.n_rx_we  <= 1'b0;
            bus.send_clr <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cs_n <= ~bus.cs_ctrl;
                    if (bus.send) begin
                        state        <= FETCH;
                        idx          <= '0;
                        end_q        <= bus.n_tx_end;
                        bus.n_rx_cnt <= '0;
                        bus.tx_addr  <= '0;
                        bus.busy     <= 1'b1;
                        bus.cs_n     <= 1'b0;
                    end
                end
                FETCH: begin
                    tx_sr    <= fill[6:0];
                    bus.mosi <= fill[7];
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (rise_pulse)
                        rx_sr <= {rx_sr[6:0], bus.miso};
                    if (fall_pulse) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // The 8th falling edge closes the byte; mosi holds until the next FETCH
                        if (bit_cnt == 3'd7) begin
                            state        <= STORE;
                            bus.rx_we    <= 1'b1;
                            bus.rx_addr  <= idx;
                            bus.rx_data  <= rx_sr;
                            bus.n_rx_cnt <= bus.n_rx_cnt + 1'b1;
                        end else begin
                            bus.mosi <= tx_sr[6];
                            tx_sr    <= {tx_sr[5:0], 1'b0};
                        end
                    end
                end
                STORE: begin
                    if (idx == end_q) begin
                        state        <= DONE;
                        bus.send_clr <= 1'b1;
                        bus.n_rx_we  <= 1'b1;
                        bus.cs_n     <= ~bus.cs_ctrl;
                    end else begin
                        idx         <= idx + 1'b1;
                        bus.tx_addr <= idx + 1'b1;
                        state       <= FETCH;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    bus.cs_n <= ~bus.cs_ctrl;
                    state    <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // The send bit is cleared one cycle late; wait for it so it cannot retrigger
                    bus.cs_n <= ~bus.cs_ctrl;
                    if (!bus.send)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed + randomized bench for spi_xfer_ctrl against a byte-level model of the burst:
// expected TX bytes from buffer/fill rules, expected RX bytes from loopback or a MISO pattern.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    localparam int N   = 5;
    localparam int DIV = 2;
    localparam int NB  = 1 << (N + 1);
    localparam int BYTE_CYC = 16 * DIV + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [7:0]  tx_mem   [NB];
    logic [7:0]  miso_pat [NB];
    logic        loop_en;
    int          miso_idx   = 0;
    int          miso_start = 0;
    int          bi;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.N(N)) bus ();

    spi_xfer_ctrl #(.N(N), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.send     = ctrl[SEND_BIT];
    assign bus.cs_ctrl  = ctrl[CS_BIT];
    assign bus.all_1s   = ctrl[ONES_BIT];
    assign bus.all_0s   = ctrl[ZEROS_BIT];
    assign bus.n_tx_end = ctrl[TX_END_LSB +: N+1];
    assign bus.tx_data  = tx_mem[bus.tx_addr];

    // MISO pattern is advanced on each SCLK fall so the slave presents bit k before rise k
    assign bi       = miso_idx - miso_start;
    assign bus.miso = loop_en ? bus.mosi
                    : ((bi >= 0 && bi < NB * 8) ? miso_pat[bi / 8][7 - (bi % 8)] : 1'b0);

    always @(negedge bus.sclk) miso_idx++;

    logic       mosi_q[$];
    logic [N:0] rxa_q[$];
    logic [7:0] rxd_q[$];
    int         n_rx_we_cnt = 0;
    int         send_clr_cnt = 0;
    int         busy_cyc = 0;
    int         cs_bad = 0;
    logic [N+1:0] n_rx_val = '0;

    always @(posedge bus.sclk) mosi_q.push_back(bus.mosi);

    always @(negedge clk) begin
        if (bus.rx_we) begin
            rxa_q.push_back(bus.rx_addr);
            rxd_q.push_back(bus.rx_data);
        end
        if (bus.n_rx_we) begin
            n_rx_we_cnt++;
            n_rx_val = bus.n_rx_cnt;
        end
        if (bus.send_clr) send_clr_cnt++;
        if (bus.busy) busy_cyc++;
        if (bus.busy && bus.cs_n && !bus.send_clr) cs_bad++;
    end

    int mosi_base, rx_base, nrxwe_base, clr_base, busy_base, cs_base;
    int cur_n;
    logic cur_ones, cur_zeros, cur_loop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic prep(input int n, input logic ones, input logic zeros, input logic loop);
        cur_n = n; cur_ones = ones; cur_zeros = zeros; cur_loop = loop;
        ctrl[TX_END_LSB +: N+1] = (N+1)'(n);
        ctrl[ONES_BIT]  = ones;
        ctrl[ZEROS_BIT] = zeros;
        loop_en    = loop;
        miso_start = miso_idx;
        mosi_base  = mosi_q.size();
        rx_base    = rxa_q.size();
        nrxwe_base = n_rx_we_cnt;
        clr_base   = send_clr_cnt;
        busy_base  = busy_cyc;
        cs_base    = cs_bad;
    endtask

    function automatic logic mosi_at(input int j);
        return (j < mosi_q.size()) ? mosi_q[j] : 1'bx;
    endfunction

    task automatic check_burst();
        int k = 0;
        logic [7:0]  txb, rxe, mb;
        logic [31:0] creg;
        while (send_clr_cnt == clr_base && k < (cur_n + 1) * BYTE_CYC + 40) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("send_clr_count", send_clr_cnt - clr_base, 1);
        check("n_rx_we_count", n_rx_we_cnt - nrxwe_base, 1);
        creg = ctrl;
        creg[RX_END_LSB +: N+2] = n_rx_val;
        check("n_rx_cnt", creg[RX_END_LSB +: N+2], cur_n + 1);
        check("sclk_rises", mosi_q.size() - mosi_base, 8 * (cur_n + 1));
        check("rx_we_count", rxa_q.size() - rx_base, cur_n + 1);
        check("busy_cycles", busy_cyc - busy_base, (cur_n + 1) * BYTE_CYC + 1);
        check("cs_n_low_in_burst", cs_bad - cs_base, 0);
        for (int i = 0; i <= cur_n; i++) begin
            txb = cur_ones ? 8'hFF : (cur_zeros ? 8'h00 : tx_mem[i]);
            rxe = cur_loop ? txb : miso_pat[i];
            mb = '0;
            for (int b = 0; b < 8; b++) mb = {mb[6:0], mosi_at(mosi_base + 8 * i + b)};
            check($sformatf("mosi_byte[%0d]", i), mb, txb);
            if (rx_base + i < rxa_q.size()) begin
                check($sformatf("rx_addr[%0d]", i), rxa_q[rx_base + i], i);
                check($sformatf("rx_data[%0d]", i), rxd_q[rx_base + i], rxe);
            end
        end
    endtask

    task automatic end_burst();
        ctrl[SEND_BIT] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n_before, rises;
        ctrl    = '0;
        loop_en = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < NB; i++) begin
            tx_mem[i]   = 8'h00;
            miso_pat[i] = 8'h00;
        end

        // Reset held with send=1, then single A5 byte in loopback
        tx_mem[0] = 8'hA5;
        prep(0, 1'b0, 1'b0, 1'b1);
        ctrl[SEND_BIT] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_we", bus.rx_we, 0);
        check("rst_n_rx_we", bus.n_rx_we, 0);
        check("rst_send_clr", bus.send_clr, 0);
        check("rst_tx_addr", bus.tx_addr, 0);
        check("rst_rx_addr", bus.rx_addr, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_n_rx_cnt", bus.n_rx_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check("start_busy", bus.busy, 1);
        check("start_cs_n", bus.cs_n, 0);
        check_burst();
        end_burst();

        // Fill mode: both fill bits set, miso tied low
        for (int i = 0; i < 4; i++) miso_pat[i] = 8'h00;
        prep(3, 1'b1, 1'b1, 1'b0);
        ctrl[SEND_BIT] = 1'b1;
        check_burst();
        end_burst();

        // Maximum burst
        for (int i = 0; i < NB; i++) tx_mem[i] = 8'(i);
        prep(NB - 1, 1'b0, 1'b0, 1'b1);
        ctrl[SEND_BIT] = 1'b1;
        check_burst();
        end_burst();

        // Randomized bursts; n_tx_end is disturbed after capture
        repeat (6) begin
            w = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                tx_mem[i]   = 8'($urandom);
                miso_pat[i] = 8'($urandom);
            end
            prep(w, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)));
            ctrl[SEND_BIT] = 1'b1;
            @(negedge clk);
            ctrl[TX_END_LSB +: N+1] = (N+1)'($urandom_range(0, NB - 1));
            check_burst();
            end_burst();
        end

        // Mid-byte abort during byte 2
        for (int i = 0; i < 6; i++) tx_mem[i] = 8'($urandom);
        prep(5, 1'b0, 1'b0, 1'b1);
        ctrl[SEND_BIT] = 1'b1;
        w = 0;
        while (rxa_q.size() - rx_base < 2 && w < 4 * BYTE_CYC) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_byte2", rxa_q.size() - rx_base, 2);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", bus.cs_n, 1);
        check("abort_sclk", bus.sclk, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rx_we", bus.rx_we, 0);
        check("abort_send_clr", bus.send_clr, 0);
        n_before = rxa_q.size();
        @(negedge clk);
        check("abort_no_rx_we", rxa_q.size() - n_before, 0);
        check("abort_no_send_clr", send_clr_cnt - clr_base, 0);
        check("abort_no_n_rx_we", n_rx_we_cnt - nrxwe_base, 0);
        prep(5, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("restart_busy", bus.busy, 1);
        check("restart_tx_addr", bus.tx_addr, 0);
        check_burst();
        end_burst();

        // Re-arm: stale send must not retrigger
        tx_mem[0] = 8'($urandom);
        tx_mem[1] = 8'($urandom);
        prep(1, 1'b0, 1'b0, 1'b1);
        ctrl[SEND_BIT] = 1'b1;
        check_burst();
        rises = mosi_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rearm_hold_busy[%0d]", i), bus.busy, 0);
        end
        check("rearm_no_rises", mosi_q.size() - rises, 0);
        ctrl[CS_BIT]   = 1'b1;
        ctrl[SEND_BIT] = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cs_ctrl", bus.cs_n, 0);
        check("idle_busy", bus.busy, 0);
        prep(1, 1'b0, 1'b0, 1'b1);
        ctrl[SEND_BIT] = 1'b1;
        @(negedge clk);
        check("rearm_start_busy", bus.busy, 1);
        check_burst();
        check("post_burst_cs_ctrl", bus.cs_n, 0);
        end_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
